ov5640_dvp_window: RTL and testbench

//  Crop stage between OV5640 DVP pins and the camera data store, in the CCD_PCLK domain.

---
 rtl/ov5640_dvp_window.sv | 103 ++++++++++
 tb/tb_ov5640_dvp_window.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ov5640_dvp_window.sv
// ov5640_dvp_window: crops the OV5640 DVP stream to a programmable window and measures frame geometry
module ov5640_dvp_window #(
  parameter int CNT_W    = 16,
  parameter int STABLE_N = 3
) (
  input  logic             CCD_PCLK,
  input  logic             CCD_RSTN,
  input  logic             CCD_VSYNC,
  input  logic             CCD_HREF,
  input  logic [7:0]       CCD_DATA,
  input  logic             enable,
  input  logic [CNT_W-1:0] win_x,
  input  logic [CNT_W-1:0] win_y,
  input  logic [CNT_W-1:0] win_w,
  input  logic [CNT_W-1:0] win_h,
  output logic             out_vsync,
  output logic             out_href,
  output logic [7:0]       out_data,
  output logic [CNT_W-1:0] meas_width,
  output logic [CNT_W-1:0] meas_height,
  output logic             frame_stable,
  output logic [7:0]       frame_cnt
);
  typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE, DONE} state_t;
  localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   ONE_W = {{CNT_W{1'b0}}, 1'b1};
  state_t state, state_nx;
  logic vs_d1, hr_d1, vs_p, hr_p;
  logic [7:0] dat_d1;
  logic [CNT_W-1:0] hcnt, vcnt, x_s, y_s, w_s, h_s, prev_w, prev_h;
  logic [CNT_W:0] x_end, y_end;
  logic [3:0] stab_cnt;
  logic fs, le, keep, last_line;
  assign fs        = vs_p & ~vs_d1;
  assign le        = hr_p & ~hr_d1;
  assign x_end     = {1'b0, x_s} + {1'b0, w_s};
  assign y_end     = {1'b0, y_s} + {1'b0, h_s};
  assign keep      = hr_d1 && state == ACTIVE && hcnt >= x_s && {1'b0, hcnt} < x_end
                     && vcnt >= y_s && {1'b0, vcnt} < y_end;
  assign last_line = le && ({1'b0, vcnt} + ONE_W == y_end);
  assign frame_stable = stab_cnt >= 4'(STABLE_N - 1);
  // pin capture plus one-cycle history for edge detection
  always_ff @(posedge CCD_PCLK or negedge CCD_RSTN)
    if (!CCD_RSTN) begin
      {vs_d1, hr_d1, vs_p, hr_p} <= '0;
      dat_d1 <= '0;
    end else begin
      vs_d1  <= CCD_VSYNC;
      hr_d1  <= CCD_HREF;
      dat_d1 <= CCD_DATA;
      vs_p   <= vs_d1;
      hr_p   <= hr_d1;
    end
  // byte and line position counters; frame start overrides line end
  always_ff @(posedge CCD_PCLK or negedge CCD_RSTN)
    if (!CCD_RSTN) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      hcnt <= (fs || le) ? '0 : hr_d1 ? hcnt + ONE_C : hcnt;
      vcnt <= fs ? '0 : le ? vcnt + ONE_C : vcnt;
    end
  // window shadows, geometry measurement and stability tracking
  always_ff @(posedge CCD_PCLK or negedge CCD_RSTN)
    if (!CCD_RSTN) begin
      {x_s, y_s, w_s, h_s} <= '0;
      {meas_width, meas_height, prev_w, prev_h} <= '0;
      stab_cnt  <= '0;
      frame_cnt <= '0;
    end else begin
      if (le) meas_width <= hcnt;
      if (fs) begin
        {x_s, y_s, w_s, h_s} <= {win_x, win_y, win_w, win_h};
        meas_height <= vcnt;
        frame_cnt   <= frame_cnt + 8'd1;
        prev_w      <= meas_width;
        prev_h      <= vcnt;
        stab_cnt    <= (meas_width == prev_w && vcnt == prev_h) ?
                       (stab_cnt == 4'd15 ? stab_cnt : stab_cnt + 4'd1) : 4'd0;
      end
    end
  // frame state register
  always_ff @(posedge CCD_PCLK or negedge CCD_RSTN)
    if (!CCD_RSTN) state <= IDLE;
    else state <= state_nx;
  // next state: enable drop wins, then a frame start re-arms the window
  always_comb begin
    state_nx = state;
    state_nx = !enable ? IDLE : state == IDLE ? WAIT_VS : fs ? ACTIVE :
               (state == ACTIVE && last_line) ? DONE : state;
  end
  // output stage; vsync held high while idle so downstream only sees frames after enable
  always_ff @(posedge CCD_PCLK or negedge CCD_RSTN)
    if (!CCD_RSTN) begin
      out_vsync <= 1'b1;
      out_href  <= 1'b0;
      out_data  <= '0;
    end else begin
      out_vsync <= state == IDLE ? 1'b1 : vs_d1;
      out_href  <= keep;
      out_data  <= keep ? dat_d1 : 8'd0;
    end
endmodule

// File: tb/tb_ov5640_dvp_window.sv
// tb_ov5640_dvp_window: scoreboard bench for the DVP window crop on small frames
module tb_ov5640_dvp_window;
  localparam int CW = 16;
  logic CCD_PCLK = 0, CCD_RSTN = 0, CCD_VSYNC = 1, CCD_HREF = 0, enable = 0;
  logic [7:0] CCD_DATA = 0;
  logic [CW-1:0] win_x = 0, win_y = 0, win_w = 16, win_h = 8;
  logic out_vsync, out_href, frame_stable;
  logic [7:0] out_data, frame_cnt;
  logic [CW-1:0] meas_width, meas_height;
  int checks = 0, errors = 0;
  logic [7:0] exq[$];

  ov5640_dvp_window #(.CNT_W(CW), .STABLE_N(3)) dut (
    .CCD_PCLK(CCD_PCLK), .CCD_RSTN(CCD_RSTN), .CCD_VSYNC(CCD_VSYNC), .CCD_HREF(CCD_HREF),
    .CCD_DATA(CCD_DATA), .enable(enable), .win_x(win_x), .win_y(win_y), .win_w(win_w),
    .win_h(win_h), .out_vsync(out_vsync), .out_href(out_href), .out_data(out_data),
    .meas_width(meas_width), .meas_height(meas_height), .frame_stable(frame_stable),
    .frame_cnt(frame_cnt));

  always #5 CCD_PCLK = ~CCD_PCLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int lines, input int bytes, input int x, input int y,
                          input int w, input int h, input int kl = -1, input int kb = 0);
    for (int l = 0; l < lines; l++)
      for (int b = 0; b < bytes; b++)
        if (b >= x && b < x + w && l >= y && l < y + h && (kl < 0 || l < kl || (l == kl && b < kb)))
          exq.push_back(8'(l * 16 + b));
  endtask

  task automatic send_frame(input int lines, input int bytes, input int kl = -1,
                            input int kb = 0, input bit reen = 0);
    @(negedge CCD_PCLK) CCD_VSYNC = 1;
    repeat (3) @(negedge CCD_PCLK);
    CCD_VSYNC = 0;
    repeat (2) @(negedge CCD_PCLK);
    if (reen) enable = 1;
    for (int l = 0; l < lines; l++) begin
      for (int b = 0; b < bytes; b++) begin
        CCD_HREF = 1;
        CCD_DATA = 8'(l * 16 + b);
        if (l == kl && b == kb) enable = 0;
        @(negedge CCD_PCLK);
      end
      CCD_HREF = 0;
      CCD_DATA = 0;
      repeat (3) @(negedge CCD_PCLK);
    end
    repeat (3) @(negedge CCD_PCLK);
  endtask

  task automatic tiny_frame();
    @(negedge CCD_PCLK) CCD_VSYNC = 1;
    repeat (2) @(negedge CCD_PCLK);
    CCD_VSYNC = 0;
    repeat (2) @(negedge CCD_PCLK);
  endtask

  task automatic set_win(input int x, input int y, input int w, input int h);
    win_x = CW'(x); win_y = CW'(y); win_w = CW'(w); win_h = CW'(h);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_vsync"}, int'(out_vsync), 1);
    chk({tag, "_href"}, int'(out_href), 0);
    chk({tag, "_data"}, int'(out_data), 0);
    chk({tag, "_mw"}, int'(meas_width), 0);
    chk({tag, "_mh"}, int'(meas_height), 0);
    chk({tag, "_stable"}, int'(frame_stable), 0);
    chk({tag, "_fcnt"}, int'(frame_cnt), 0);
  endtask

  initial begin
    repeat (3) @(negedge CCD_PCLK);
    chk_reset_vals("reset");
    CCD_RSTN = 1;
    enable = 1;
    fork
      forever begin
        @(negedge CCD_PCLK);
        if (CCD_RSTN && out_href) begin
          checks++;
          if (exq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_byte got %0d want none", out_data);
          end else begin
            logic [7:0] e;
            e = exq.pop_front();
            if (out_data !== e) begin
              errors++;
              $display("FAIL out_data got %0d want %0d", out_data, e);
            end
          end
        end
      end
    join_none
    set_win(0, 0, 16, 8); push_exp(8, 16, 0, 0, 16, 8); send_frame(8, 16);
    chk("f1_drain", exq.size(), 0);
    chk("f1_mw", int'(meas_width), 16);
    chk("f1_fcnt", int'(frame_cnt), 1);
    chk("f1_stable", int'(frame_stable), 0);
    set_win(2, 1, 5, 3); push_exp(8, 16, 2, 1, 5, 3); send_frame(8, 16);
    chk("f2_drain", exq.size(), 0);
    chk("f2_mh", int'(meas_height), 8);
    chk("f2_stable", int'(frame_stable), 0);
    set_win(12, 6, 10, 10); push_exp(8, 16, 12, 6, 10, 10); send_frame(8, 16);
    chk("f3_clip_drain", exq.size(), 0);
    chk("f3_stable", int'(frame_stable), 0);
    set_win(0, 0, 16, 8); push_exp(8, 16, 0, 0, 16, 8); send_frame(8, 16);
    chk("f4_drain", exq.size(), 0);
    chk("f4_stable", int'(frame_stable), 1);
    push_exp(7, 16, 0, 0, 16, 8); send_frame(7, 16);
    chk("f5_drain", exq.size(), 0);
    chk("f5_stable", int'(frame_stable), 1);
    set_win(0, 0, 0, 8); send_frame(8, 16);
    chk("f6_w0_drain", exq.size(), 0);
    chk("f6_vsync_fwd", int'(out_vsync), 0);
    chk("f6_mh", int'(meas_height), 7);
    chk("f6_stable", int'(frame_stable), 0);
    set_win(0, 0, 16, 8); push_exp(8, 16, 0, 0, 16, 8);
    fork
      send_frame(8, 16);
      begin repeat (40) @(negedge CCD_PCLK); win_h = 4; end
    join
    chk("f7_midchg_drain", exq.size(), 0);
    push_exp(8, 16, 0, 0, 16, 4); send_frame(8, 16);
    chk("f8_h4_drain", exq.size(), 0);
    win_h = 8; push_exp(8, 16, 0, 0, 16, 8, 3, 6); send_frame(8, 16, 3, 6);
    chk("f9_kill_drain", exq.size(), 0);
    chk("f9_vsync_idle", int'(out_vsync), 1);
    chk("f9_href", int'(out_href), 0);
    send_frame(8, 16, -1, 0, 1);
    chk("f10_reen_drain", exq.size(), 0);
    push_exp(8, 16, 0, 0, 16, 8); send_frame(8, 16);
    chk("f11_drain", exq.size(), 0);
    chk("f11_fcnt", int'(frame_cnt), 11);
    set_win(0, 6, 16, 2);
    fork
      send_frame(8, 16);
      begin
        repeat (66) @(negedge CCD_PCLK);
        CCD_RSTN = 0;
        #1 chk_reset_vals("midreset");
        @(negedge CCD_PCLK) CCD_RSTN = 1;
      end
    join
    chk("f12_drain", exq.size(), 0);
    for (int i = 0; i < 255; i++) tiny_frame();
    chk("fcnt_255", int'(frame_cnt), 255);
    tiny_frame();
    chk("fcnt_wrap", int'(frame_cnt), 0);
    set_win(0, 0, 16, 8); push_exp(8, 16, 0, 0, 16, 8); send_frame(8, 16);
    chk("resume_drain", exq.size(), 0);
    chk("resume_mw", int'(meas_width), 16);
    chk("resume_fcnt", int'(frame_cnt), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
